// File: rtl/xram_collision_sequencer.sv
// Fixed-program stimulus sequencer for the dual-port RAM collision harness: init writes, flush, A- and B-write collisions.
// All outputs registered; sample strobes trail the collision/hold cycles by READ_LATENCY; no backpressure, start is sampled only in IDLE.
module xram_collision_sequencer #(
    parameter int ADDRESS_BITS = 10,
    parameter int DATA_BITS    = 32,
    parameter int INIT_WORDS   = 4,
    parameter int INIT_VALUE   = 255,
    parameter int COLL_ADDR_A  = 1,
    parameter int COLL_ADDR_B  = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    start,
    output logic [ADDRESS_BITS-1:0] address_a,
    output logic [DATA_BITS-1:0]    data_a,
    output logic                    write_enable_a,
    output logic                    read_enable_a,
    output logic [ADDRESS_BITS-1:0] address_b,
    output logic [DATA_BITS-1:0]    data_b,
    output logic                    write_enable_b,
    output logic                    read_enable_b,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              phase,
    output logic                    sample_coll,
    output logic                    sample_hold,
    output logic                    sample_port
);

    localparam int CW = ($clog2(INIT_WORDS) > 2) ? $clog2(INIT_WORDS) : 2;

    localparam logic [ADDRESS_BITS-1:0] ADDR_COLL_A = ADDRESS_BITS'(COLL_ADDR_A);
    localparam logic [ADDRESS_BITS-1:0] ADDR_COLL_B = ADDRESS_BITS'(COLL_ADDR_B);
    localparam logic [DATA_BITS-1:0]    INIT_DATA   = DATA_BITS'(INIT_VALUE);
    localparam logic [CW-1:0]           INIT_LOAD   = CW'(INIT_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_FLUSH  = 4'd2,
        S_GAP0   = 4'd3,
        S_COLL_A = 4'd4,
        S_HOLD_A = 4'd5,
        S_GAP1   = 4'd6,
        S_COLL_B = 4'd7,
        S_HOLD_B = 4'd8,
        S_GAP2   = 4'd9,
        S_DONE   = 4'd10
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nx;
    logic [ADDRESS_BITS-1:0] address_a_nx;
    logic [ADDRESS_BITS-1:0] address_b_nx;
    logic [DATA_BITS-1:0]    data_a_nx;
    logic [DATA_BITS-1:0]    data_b_nx;
    logic                    we_a_nx;
    logic                    we_b_nx;
    logic                    re_a_nx;
    logic                    re_b_nx;
    logic                    busy_nx;
    logic                    done_nx;
    logic                    coll_now;
    logic                    hold_now;
    logic                    port_now;

    logic [READ_LATENCY-1:0] coll_pipe;
    logic [READ_LATENCY-1:0] hold_pipe;
    logic [READ_LATENCY-1:0] port_pipe;

    // The combinational block picks the next state and, in the same step, the port
    // values belonging to that next state, so registered outputs line up with phase.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        address_a_nx = address_a;
        address_b_nx = address_b;
        data_a_nx    = data_a;
        data_b_nx    = data_b;
        we_a_nx      = 1'b0;
        we_b_nx      = 1'b0;
        re_a_nx      = 1'b0;
        re_b_nx      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx     = S_INIT;
                    cnt_nx       = INIT_LOAD;
                    address_a_nx = '0;
                    data_a_nx    = INIT_DATA;
                    we_a_nx      = 1'b1;
                end
            end
            S_INIT: begin
                if (cnt == '0) begin
                    state_nx     = S_FLUSH;
                    address_a_nx = '0;
                    address_b_nx = '0;
                    re_a_nx      = 1'b1;
                    re_b_nx      = 1'b1;
                end else begin
                    cnt_nx       = cnt - CW'(1);
                    address_a_nx = address_a + ADDRESS_BITS'(1);
                    data_a_nx    = INIT_DATA;
                    we_a_nx      = 1'b1;
                end
            end
            S_FLUSH: begin
                state_nx = S_GAP0;
                cnt_nx   = CW'(1);
            end
            S_GAP0: begin
                if (cnt == '0) begin
                    state_nx     = S_COLL_A;
                    address_a_nx = ADDR_COLL_A;
                    address_b_nx = ADDR_COLL_A;
                    data_a_nx    = DATA_BITS'(8);
                    data_b_nx    = DATA_BITS'(9);
                    re_a_nx      = 1'b1;
                    re_b_nx      = 1'b1;
                    we_a_nx      = 1'b1;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_COLL_A: begin
                state_nx     = S_HOLD_A;
                address_a_nx = ADDR_COLL_A;
                address_b_nx = ADDR_COLL_A;
                data_a_nx    = DATA_BITS'(8);
                data_b_nx    = DATA_BITS'(9);
                re_a_nx      = 1'b1;
                re_b_nx      = 1'b1;
            end
            S_HOLD_A: begin
                state_nx = S_GAP1;
                cnt_nx   = CW'(2);
            end
            S_GAP1: begin
                if (cnt == '0) begin
                    state_nx     = S_COLL_B;
                    address_a_nx = ADDR_COLL_B;
                    address_b_nx = ADDR_COLL_B;
                    data_a_nx    = DATA_BITS'(18);
                    data_b_nx    = DATA_BITS'(19);
                    re_a_nx      = 1'b1;
                    re_b_nx      = 1'b1;
                    we_b_nx      = 1'b1;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_COLL_B: begin
                state_nx     = S_HOLD_B;
                address_a_nx = ADDR_COLL_B;
                address_b_nx = ADDR_COLL_B;
                data_a_nx    = DATA_BITS'(18);
                data_b_nx    = DATA_BITS'(19);
                re_a_nx      = 1'b1;
                re_b_nx      = 1'b1;
            end
            S_HOLD_B: begin
                state_nx = S_GAP2;
                cnt_nx   = CW'(1);
            end
            S_GAP2: begin
                if (cnt == '0) begin
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        busy_nx  = (state_nx != S_IDLE) && (state_nx != S_DONE);
        done_nx  = (state_nx == S_DONE);
        coll_now = (state == S_COLL_A) || (state == S_COLL_B);
        hold_now = (state == S_HOLD_A) || (state == S_HOLD_B);
        port_now = (state == S_COLL_B) || (state == S_HOLD_B);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state          <= S_IDLE;
            cnt            <= '0;
            address_a      <= '0;
            address_b      <= '0;
            data_a         <= '0;
            data_b         <= '0;
            write_enable_a <= 1'b0;
            write_enable_b <= 1'b0;
            read_enable_a  <= 1'b0;
            read_enable_b  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            address_a      <= address_a_nx;
            address_b      <= address_b_nx;
            data_a         <= data_a_nx;
            data_b         <= data_b_nx;
            write_enable_a <= we_a_nx;
            write_enable_b <= we_b_nx;
            read_enable_a  <= re_a_nx;
            read_enable_b  <= re_b_nx;
            busy           <= busy_nx;
            done           <= done_nx;
        end
    end

    // Strobe delay line keyed off the registered state: stage 0 reflects the
    // cycle the ports were driven, so the tap at READ_LATENCY-1 lands on RAM data.
    always_ff @(posedge clock) begin
        if (clear) begin
            coll_pipe <= '0;
            hold_pipe <= '0;
            port_pipe <= '0;
        end else begin
            coll_pipe[0] <= coll_now;
            hold_pipe[0] <= hold_now;
            port_pipe[0] <= port_now;
            for (int i = 1; i < READ_LATENCY; i++) begin
                coll_pipe[i] <= coll_pipe[i-1];
                hold_pipe[i] <= hold_pipe[i-1];
                port_pipe[i] <= port_pipe[i-1];
            end
        end
    end

    assign phase       = state;
    assign sample_coll = coll_pipe[READ_LATENCY-1];
    assign sample_hold = hold_pipe[READ_LATENCY-1];
    assign sample_port = port_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_xram_collision_sequencer.sv
// Bench for xram_collision_sequencer: three parameterisations share one stimulus stream and a program-level model.
module tb_xram_collision_sequencer;

    logic clock = 1'b0;
    logic clear;
    logic start;

    always #5 clock = ~clock;

    logic [9:0]  addr_a [3];
    logic [9:0]  addr_b [3];
    logic [31:0] dat_a  [3];
    logic [31:0] dat_b  [3];
    logic        we_a   [3];
    logic        we_b   [3];
    logic        re_a   [3];
    logic        re_b   [3];
    logic        busy   [3];
    logic        done   [3];
    logic [3:0]  phase  [3];
    logic        s_coll [3];
    logic        s_hold [3];
    logic        s_port [3];

    xram_collision_sequencer #(.INIT_WORDS(4), .INIT_VALUE(255), .COLL_ADDR_A(1), .COLL_ADDR_B(2),
                               .READ_LATENCY(1)) u_dut0 (
        .clock(clock), .clear(clear), .start(start),
        .address_a(addr_a[0]), .data_a(dat_a[0]), .write_enable_a(we_a[0]), .read_enable_a(re_a[0]),
        .address_b(addr_b[0]), .data_b(dat_b[0]), .write_enable_b(we_b[0]), .read_enable_b(re_b[0]),
        .busy(busy[0]), .done(done[0]), .phase(phase[0]),
        .sample_coll(s_coll[0]), .sample_hold(s_hold[0]), .sample_port(s_port[0]));

    xram_collision_sequencer #(.INIT_WORDS(4), .INIT_VALUE(255), .COLL_ADDR_A(1), .COLL_ADDR_B(2),
                               .READ_LATENCY(2)) u_dut1 (
        .clock(clock), .clear(clear), .start(start),
        .address_a(addr_a[1]), .data_a(dat_a[1]), .write_enable_a(we_a[1]), .read_enable_a(re_a[1]),
        .address_b(addr_b[1]), .data_b(dat_b[1]), .write_enable_b(we_b[1]), .read_enable_b(re_b[1]),
        .busy(busy[1]), .done(done[1]), .phase(phase[1]),
        .sample_coll(s_coll[1]), .sample_hold(s_hold[1]), .sample_port(s_port[1]));

    xram_collision_sequencer #(.INIT_WORDS(1), .INIT_VALUE(165), .COLL_ADDR_A(7), .COLL_ADDR_B(7),
                               .READ_LATENCY(3)) u_dut2 (
        .clock(clock), .clear(clear), .start(start),
        .address_a(addr_a[2]), .data_a(dat_a[2]), .write_enable_a(we_a[2]), .read_enable_a(re_a[2]),
        .address_b(addr_b[2]), .data_b(dat_b[2]), .write_enable_b(we_b[2]), .read_enable_b(re_b[2]),
        .busy(busy[2]), .done(done[2]), .phase(phase[2]),
        .sample_coll(s_coll[2]), .sample_hold(s_hold[2]), .sample_port(s_port[2]));

    int p_iw [3] = '{4, 4, 1};
    int p_iv [3] = '{255, 255, 165};
    int p_ca [3] = '{1, 1, 7};
    int p_cb [3] = '{2, 2, 7};
    int p_rl [3] = '{1, 2, 3};

    typedef struct {
        int phase;
        bit wa, wb, ra, rb;
        bit la, lb, lda, ldb;
        int aa, ab, da, db;
    } step_t;

    typedef struct {
        int phase;
        int aa, ab, da, db;
        bit wa, wb, ra, rb;
        bit sc, sh, sp;
    } exp_t;

    step_t prog [3][$];
    exp_t  ex   [3];
    int    hist [3][4096];
    int    cyc      = 0;
    int    clr_cyc  = -100;
    bit    checking = 1'b0;
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
        end
    endtask

    function automatic step_t mk(input int ph, input bit wa, input bit wb, input bit ra, input bit rb,
                                 input bit la, input int aa, input bit lb, input int ab,
                                 input bit lda, input int da, input bit ldb, input int db);
        step_t s;
        s.phase = ph; s.wa = wa; s.wb = wb; s.ra = ra; s.rb = rb;
        s.la = la; s.aa = aa; s.lb = lb; s.ab = ab;
        s.lda = lda; s.da = da; s.ldb = ldb; s.db = db;
        return s;
    endfunction

    // Expand the test program into one entry per output cycle.
    task automatic build(input int k);
        for (int i = 0; i < p_iw[k]; i++) prog[k].push_back(mk(1, 1, 0, 0, 0, 1, i, 0, 0, 1, p_iv[k], 0, 0));
        prog[k].push_back(mk(2, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) prog[k].push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        prog[k].push_back(mk(4, 1, 0, 1, 1, 1, p_ca[k], 1, p_ca[k], 1, 8, 1, 9));
        prog[k].push_back(mk(5, 0, 0, 1, 1, 1, p_ca[k], 1, p_ca[k], 1, 8, 1, 9));
        for (int i = 0; i < 3; i++) prog[k].push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        prog[k].push_back(mk(7, 0, 1, 1, 1, 1, p_cb[k], 1, p_cb[k], 1, 18, 1, 19));
        prog[k].push_back(mk(8, 0, 0, 1, 1, 1, p_cb[k], 1, p_cb[k], 1, 18, 1, 19));
        for (int i = 0; i < 2; i++) prog[k].push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        prog[k].push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    function automatic logic [127:0] exp_vec(input int k);
        bit b, d;
        b = (ex[k].phase != 0) && (ex[k].phase != 10);
        d = (ex[k].phase == 10);
        return {32'd0, 4'(ex[k].phase), 10'(ex[k].aa), 32'(ex[k].da), ex[k].wa, ex[k].ra,
                10'(ex[k].ab), 32'(ex[k].db), ex[k].wb, ex[k].rb, b, d, ex[k].sc, ex[k].sh};
    endfunction

    function automatic logic [127:0] act_vec(input int k);
        return {32'd0, phase[k], addr_a[k], dat_a[k], we_a[k], re_a[k],
                addr_b[k], dat_b[k], we_b[k], re_b[k], busy[k], done[k], s_coll[k], s_hold[k]};
    endfunction

    // Model: advances once per rising edge using the inputs held during the previous cycle.
    initial begin
        for (int k = 0; k < 3; k++) ex[k] = '{default: 0};
        forever begin
            @(posedge clock);
            if (clear) clr_cyc = cyc;
            cyc++;
            for (int k = 0; k < 3; k++) begin
                int src;
                if (clear) begin
                    ex[k] = '{default: 0};
                    prog[k].delete();
                end else begin
                    if (prog[k].size() == 0 && ex[k].phase == 0 && start) build(k);
                    if (prog[k].size() > 0) begin
                        step_t s;
                        s = prog[k].pop_front();
                        ex[k].phase = s.phase;
                        ex[k].wa = s.wa; ex[k].wb = s.wb; ex[k].ra = s.ra; ex[k].rb = s.rb;
                        if (s.la)  ex[k].aa = s.aa;
                        if (s.lb)  ex[k].ab = s.ab;
                        if (s.lda) ex[k].da = s.da;
                        if (s.ldb) ex[k].db = s.db;
                    end else begin
                        ex[k].phase = 0;
                        ex[k].wa = 0; ex[k].wb = 0; ex[k].ra = 0; ex[k].rb = 0;
                    end
                end
                hist[k][cyc % 4096] = ex[k].phase;
                src = cyc - p_rl[k];
                ex[k].sc = 0; ex[k].sh = 0; ex[k].sp = 0;
                if (src >= 0 && src > clr_cyc) begin
                    int ph;
                    ph = hist[k][src % 4096];
                    ex[k].sc = (ph == 4) || (ph == 7);
                    ex[k].sh = (ph == 5) || (ph == 8);
                    ex[k].sp = (ph == 7) || (ph == 8);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (checking) begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("inst%0d_outputs", k), act_vec(k), exp_vec(k));
                    if (ex[k].sc || ex[k].sh)
                        check($sformatf("inst%0d_sample_port", k), 128'(s_port[k]), 128'(ex[k].sp));
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    int t;

    initial begin
        clear = 1'b1;
        start = 1'b0;
        @(negedge clock);
        checking = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        idle(5);
        check("idle_phase_busy", {phase[0], busy[0], done[0], s_coll[0]}, 7'd0);

        // Run 1: default timing, sample alignment, parameter sweep.
        t = cyc; start = 1'b1; @(negedge clock); start = 1'b0;
        wait_cyc(t + 1);
        check("d_init0", {phase[0], addr_a[0], dat_a[0], we_a[0]}, {4'd1, 10'd0, 32'd255, 1'b1});
        check("s_init0", {phase[2], addr_a[2], dat_a[2], we_a[2]}, {4'd1, 10'd0, 32'h0A5, 1'b1});
        wait_cyc(t + 2);
        check("s_flush", phase[2], 4'd2);
        wait_cyc(t + 5);
        check("d_flush", {phase[0], re_a[0], re_b[0], we_a[0]}, {4'd2, 1'b1, 1'b1, 1'b0});
        check("s_coll_a", {phase[2], addr_a[2], addr_b[2], we_a[2]}, {4'd4, 10'd7, 10'd7, 1'b1});
        wait_cyc(t + 8);
        check("d_coll_a", {phase[0], addr_a[0], addr_b[0], dat_a[0], dat_b[0], we_a[0], we_b[0], re_a[0], re_b[0]},
              {4'd4, 10'd1, 10'd1, 32'd8, 32'd9, 1'b1, 1'b0, 1'b1, 1'b1});
        wait_cyc(t + 9);
        check("d_samp_coll_a", {phase[0], s_coll[0], s_port[0]}, {4'd5, 1'b1, 1'b0});
        wait_cyc(t + 10);
        check("d_samp_hold_a", s_hold[0], 1'b1);
        check("l2_samp_coll_a", {s_coll[1], s_port[1]}, {1'b1, 1'b0});
        check("s_coll_b", {phase[2], addr_a[2], we_b[2]}, {4'd7, 10'd7, 1'b1});
        wait_cyc(t + 11);
        check("l2_samp_hold_a", s_hold[1], 1'b1);
        wait_cyc(t + 13);
        check("d_coll_b", {phase[0], addr_a[0], dat_a[0], dat_b[0], we_b[0]},
              {4'd7, 10'd2, 32'd18, 32'd19, 1'b1});
        wait_cyc(t + 14);
        check("d_samp_coll_b", {s_coll[0], s_port[0]}, {1'b1, 1'b1});
        check("s_done", {phase[2], done[2]}, {4'd10, 1'b1});
        wait_cyc(t + 15);
        check("l2_samp_coll_b", {s_coll[1], s_port[1]}, {1'b1, 1'b1});
        wait_cyc(t + 16);
        check("d_busy_last", {busy[0], done[0]}, {1'b1, 1'b0});
        check("l2_samp_hold_b", s_hold[1], 1'b1);
        wait_cyc(t + 17);
        check("d_done", {phase[0], busy[0], done[0]}, {4'd10, 1'b0, 1'b1});
        wait_cyc(t + 18);
        check("d_idle_after", {phase[0], busy[0], done[0]}, {4'd0, 1'b0, 1'b0});
        idle(10);

        // Run 2: start pulses while busy and during DONE are ignored.
        t = cyc; start = 1'b1; @(negedge clock); start = 1'b0;
        wait_cyc(t + 6); start = 1'b1; @(negedge clock); start = 1'b0;
        wait_cyc(t + 17); start = 1'b1; @(negedge clock); start = 1'b0;
        wait_cyc(t + 18);
        check("ign_idle", {phase[0], busy[0]}, {4'd0, 1'b0});
        wait_cyc(t + 19);
        check("ign_no_restart", phase[0], 4'd0);
        idle(25);

        // Run 3: clear during the port-A collision cycle.
        t = cyc; start = 1'b1; @(negedge clock); start = 1'b0;
        wait_cyc(t + 8); clear = 1'b1; @(negedge clock); clear = 1'b0;
        wait_cyc(t + 9);
        check("clr_all_zero", {act_vec(0), s_port[0]}, 129'd0);
        idle(5);
        t = cyc; start = 1'b1; @(negedge clock); start = 1'b0;
        wait_cyc(t + 8);
        check("clr_rerun_coll_a", {phase[0], addr_a[0], dat_a[0], dat_b[0], we_a[0]},
              {4'd4, 10'd1, 32'd8, 32'd9, 1'b1});
        idle(25);

        // Random start/clear traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 5) == 0);
            clear = ($urandom_range(0, 49) == 0);
            @(negedge clock);
        end
        start = 1'b0;
        clear = 1'b0;
        idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
